// File: rtl/counter_checker.sv
// -----------------------------------------------------------------------------
// counter_checker
//
// Receive-side checker for a counter stream. Each enabled clock it samples
// din, predicts the next value using the same COUNT_FROM/COUNT_TO/STEP wrap
// rules as the generating counter, locks onto the sequence after LOCK_COUNT
// consecutive correct transitions and, once locked, flags and counts
// mismatches. UNLOCK_ERRS consecutive mismatches while locked send it back
// to searching.
//
// Optional feature macro: COUNTER_CHECKER_CLR_EN
//   defined     -> clr port present, synchronous clear of err_count
//   not defined -> no clr port, err_count cleared only by rst
//
// Ports
//   clk        in   1           clock, rising edge
//   rst        in   1           asynchronous reset, active-high
//   en         in   1           din valid this cycle
//   din        in   DATA_WIDTH  received counter value
//   clr        in   1           (COUNTER_CHECKER_CLR_EN only) clear err_count
//   locked     out  1           checker is locked to the sequence
//   error      out  1           one-cycle pulse per mismatched sample while locked
//   err_count  out  ERR_WIDTH   saturating mismatch count since reset/clear
// -----------------------------------------------------------------------------
module counter_checker #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_FROM  = 0,
    parameter int unsigned COUNT_TO    = 255,
    parameter int unsigned STEP        = 1,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned UNLOCK_ERRS = 4,
    parameter int unsigned ERR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
`ifdef COUNTER_CHECKER_CLR_EN
    input  logic                  clr,
`endif
    output logic                  locked,
    output logic                  error,
    output logic [ERR_WIDTH-1:0]  err_count
);

    localparam int unsigned MATCH_W = (LOCK_COUNT  < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W  = (UNLOCK_ERRS < 1) ? 1 : $clog2(UNLOCK_ERRS + 1);

    // Wrap test is done two bits wider than the data so v+STEP never overflows;
    // this is equivalent to v > COUNT_TO-STEP without an underflowing subtract.
    localparam logic [DATA_WIDTH+1:0] STEP_X  = (DATA_WIDTH+2)'(STEP);
    localparam logic [DATA_WIDTH+1:0] TO_X    = (DATA_WIDTH+2)'(COUNT_TO);
    localparam logic [DATA_WIDTH-1:0] STEP_D  = DATA_WIDTH'(STEP);
    localparam logic [DATA_WIDTH-1:0] FROM_D  = DATA_WIDTH'(COUNT_FROM);
    localparam logic [MATCH_W-1:0]    LOCK_M  = MATCH_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0]     UNLK_M  = MISS_W'(UNLOCK_ERRS);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] f_next(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH+1:0] sum;
        sum = {2'b00, v} + STEP_X;
        if (sum > TO_X) begin
            f_next = FROM_D;
        end else begin
            f_next = v + STEP_D;
        end
    endfunction

    // registered state
    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_expected;
    logic                    r_seeded;
    logic [MATCH_W-1:0]      r_match_cnt;
    logic [MISS_W-1:0]       r_miss_cnt;
    logic                    r_locked;
    logic                    r_error;
    logic [ERR_WIDTH-1:0]    r_err_count;

    // next-state / combinational helpers
    state_t                  w_state_nx;
    logic [DATA_WIDTH-1:0]   w_expected_nx;
    logic                    w_seeded_nx;
    logic [MATCH_W-1:0]      w_match_nx;
    logic [MISS_W-1:0]       w_miss_nx;
    logic                    w_locked_nx;
    logic                    w_error_nx;
    logic [ERR_WIDTH-1:0]    w_err_nx;
    logic                    w_mismatch;
    logic [DATA_WIDTH-1:0]   w_next_din;
    logic [DATA_WIDTH-1:0]   w_next_exp;
    logic                    w_din_ok;
    logic [MATCH_W-1:0]      w_match_inc;
    logic [MISS_W-1:0]       w_miss_inc;

    assign w_next_din  = f_next(din);
    assign w_next_exp  = f_next(r_expected);
    assign w_din_ok    = (din == r_expected);
    assign w_match_inc = r_match_cnt + 1'b1;
    assign w_miss_inc  = r_miss_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_expected  <= '0;
            r_seeded    <= 1'b0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_expected  <= w_expected_nx;
            r_seeded    <= w_seeded_nx;
            r_match_cnt <= w_match_nx;
            r_miss_cnt  <= w_miss_nx;
            r_locked    <= w_locked_nx;
            r_error     <= w_error_nx;
            r_err_count <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_expected_nx = r_expected;
        w_seeded_nx   = r_seeded;
        w_match_nx    = r_match_cnt;
        w_miss_nx     = r_miss_cnt;
        w_locked_nx   = r_locked;
        w_error_nx    = 1'b0;
        w_err_nx      = r_err_count;
        w_mismatch    = 1'b0;

        if (en) begin
            case (r_state)
                ST_SEARCH: begin
                    // While searching the prediction always resyncs to din.
                    w_expected_nx = w_next_din;
                    if (!r_seeded) begin
                        w_seeded_nx = 1'b1;
                    end else if (w_din_ok) begin
                        if (w_match_inc == LOCK_M) begin
                            w_state_nx  = ST_LOCKED;
                            w_locked_nx = 1'b1;
                            w_match_nx  = '0;
                            w_miss_nx   = '0;
                        end else begin
                            w_match_nx = w_match_inc;
                        end
                    end else begin
                        w_match_nx = '0;
                    end
                end
                ST_LOCKED: begin
                    // Once locked the prediction free-runs so a corrupted
                    // word cannot drag the expected sequence along with it.
                    w_expected_nx = w_next_exp;
                    if (w_din_ok) begin
                        w_miss_nx = '0;
                    end else begin
                        w_mismatch = 1'b1;
                        w_error_nx = 1'b1;
                        if (r_err_count != '1) begin
                            w_err_nx = r_err_count + 1'b1;
                        end
                        if (w_miss_inc == UNLK_M) begin
                            w_state_nx  = ST_SEARCH;
                            w_locked_nx = 1'b0;
                            w_match_nx  = '0;
                            w_miss_nx   = '0;
                            w_seeded_nx = 1'b0;
                        end else begin
                            w_miss_nx = w_miss_inc;
                        end
                    end
                end
                default: begin
                    w_state_nx  = ST_SEARCH;
                    w_locked_nx = 1'b0;
                end
            endcase
        end

`ifdef COUNTER_CHECKER_CLR_EN
        // A mismatch on the clearing edge is kept, so the count restarts at 1.
        if (clr) begin
            w_err_nx = w_mismatch ? ERR_WIDTH'(1) : '0;
        end
`endif
    end

    assign locked    = r_locked;
    assign error     = r_error;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_checker
//
// Three checker instances: defaults, a 10..20 step-3 sequence, and a 2-bit
// error counter. A driver issues directed samples and queues the expected
// registered outputs; a monitor pops one entry per clock and compares.
// -----------------------------------------------------------------------------
module tb_counter_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic [7:0]  din0 = '0, din1 = '0, din2 = '0;
    logic        locked0, locked1, locked2;
    logic        error0, error1, error2;
    logic [15:0] err0, err1;
    logic [1:0]  err2;
`ifdef COUNTER_CHECKER_CLR_EN
    logic        clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          id;
        logic        xl;
        logic        xe;
        logic [15:0] xc;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_checker dut0 (
        .clk(clk), .rst(rst), .en(en0), .din(din0),
`ifdef COUNTER_CHECKER_CLR_EN
        .clr(clr0),
`endif
        .locked(locked0), .error(error0), .err_count(err0)
    );

    counter_checker #(
        .COUNT_FROM(10), .COUNT_TO(20), .STEP(3)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en1), .din(din1),
`ifdef COUNTER_CHECKER_CLR_EN
        .clr(clr1),
`endif
        .locked(locked1), .error(error1), .err_count(err1)
    );

    counter_checker #(
        .ERR_WIDTH(2)
    ) dut2 (
        .clk(clk), .rst(rst), .en(en2), .din(din2),
`ifdef COUNTER_CHECKER_CLR_EN
        .clr(clr2),
`endif
        .locked(locked2), .error(error2), .err_count(err2)
    );

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Drive one sample at the falling edge and queue what the outputs must
    // show after the following rising edge.
    task automatic send(input int id, input logic e, input logic [7:0] d,
                        input logic c, input logic xl, input logic xe,
                        input logic [15:0] xc, input string tag);
        exp_t it;
        @(negedge clk);
        en0 = 1'b0;
        en1 = 1'b0;
        en2 = 1'b0;
`ifdef COUNTER_CHECKER_CLR_EN
        clr0 = 1'b0;
        clr1 = 1'b0;
        clr2 = c;
`endif
        case (id)
            0: begin en0 = e; din0 = d; end
            1: begin en1 = e; din1 = d; end
            default: begin en2 = e; din2 = d; end
        endcase
        it.id  = id;
        it.xl  = xl;
        it.xe  = xe;
        it.xc  = c ? xc : xc;
        it.tag = tag;
        sb.push_back(it);
    endtask

    // Monitor: one queued expectation per rising edge, compared just after it.
    always @(posedge clk) begin
        exp_t        it;
        logic        al, ae;
        logic [15:0] ac;
        #1;
        if (sb.size() != 0) begin
            it = sb.pop_front();
            case (it.id)
                0: begin al = locked0; ae = error0; ac = err0; end
                1: begin al = locked1; ae = error1; ac = err1; end
                default: begin al = locked2; ae = error2; ac = {14'b0, err2}; end
            endcase
            check({it.tag, ".locked"}, {15'b0, al}, {15'b0, it.xl});
            check({it.tag, ".error"},  {15'b0, ae}, {15'b0, it.xe});
            check({it.tag, ".err_count"}, ac, it.xc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v;
        logic [7:0]  e;
        logic [7:0]  seq [4];
        logic [15:0] sat;
        logic        r_en;

        seq[0] = 8'd10; seq[1] = 8'd13; seq[2] = 8'd16; seq[3] = 8'd19;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state of all instances
        send(0, 1'b0, 8'h5a, 1'b0, 1'b0, 1'b0, 16'd0, "rst0");
        send(1, 1'b0, 8'h5a, 1'b0, 1'b0, 1'b0, 16'd0, "rst1");
        send(2, 1'b0, 8'h5a, 1'b0, 1'b0, 1'b0, 16'd0, "rst2");

        // 1: clean ramp with wrap; locks on the edge sampling din=4
        for (int i = 0; i < 300; i++) begin
            v = 8'(i);
            send(0, 1'b1, v, 1'b0, (i >= 4), 1'b0, 16'd0, "ramp");
        end
        v = 8'd44;

        // 2: single substituted word while locked
        while (v != 8'd50) begin
            send(0, 1'b1, v, 1'b0, 1'b1, 1'b0, 16'd0, "pre_sub");
            v++;
        end
        send(0, 1'b1, 8'd77, 1'b0, 1'b1, 1'b1, 16'd1, "sub77");
        v++;
        for (int i = 0; i < 10; i++) begin
            send(0, 1'b1, v, 1'b0, 1'b1, 1'b0, 16'd1, "post_sub");
            v++;
        end

        // 3: four consecutive bad words unlock, then relock on a new ramp
        for (int k = 0; k < 4; k++) begin
            send(0, 1'b1, 8'd200, 1'b0, (k < 3), 1'b1, 16'(2 + k), "burst");
        end
        for (int j = 0; j < 11; j++) begin
            send(0, 1'b1, 8'(100 + j), 1'b0, (j >= 4), 1'b0, 16'd5, "relock");
        end
        v = 8'd111;

        // 5: gapped enable with garbage on idle cycles
        for (int i = 0; i < 40; i++) begin
            r_en = 1'($urandom_range(0, 1));
            if (r_en) begin
                send(0, 1'b1, v, 1'b0, 1'b1, 1'b0, 16'd5, "gap_on");
                v++;
            end else begin
                send(0, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 16'd5, "gap_off");
            end
        end
        send(0, 1'b1, v + 8'd100, 1'b0, 1'b1, 1'b1, 16'd6, "gap_err");
        v++;
        send(0, 1'b0, 8'hff, 1'b0, 1'b1, 1'b0, 16'd6, "err_then_idle");
        send(0, 1'b1, v, 1'b0, 1'b1, 1'b0, 16'd6, "after_idle");
        v++;
        send(0, 1'b1, v, 1'b0, 1'b1, 1'b0, 16'd6, "after_idle2");

        // 4: 10..20 step 3 sequence, wrap 19->10, then 20 is wrong
        for (int i = 0; i < 12; i++) begin
            send(1, 1'b1, seq[i % 4], 1'b0, (i >= 4), 1'b0, 16'd0, "seq3");
        end
        send(1, 1'b1, 8'd20, 1'b0, 1'b1, 1'b1, 16'd1, "seq3_bad20");
        send(1, 1'b1, 8'd13, 1'b0, 1'b1, 1'b0, 16'd1, "seq3_13");
        send(1, 1'b1, 8'd16, 1'b0, 1'b1, 1'b0, 16'd1, "seq3_16");

        // 6: 2-bit error counter saturates at 3 over isolated errors
        for (int i = 0; i < 5; i++) begin
            send(2, 1'b1, 8'(i), 1'b0, (i >= 4), 1'b0, 16'd0, "sat_lock");
        end
        e = 8'd5;
        for (int k = 0; k < 5; k++) begin
            sat = (k >= 2) ? 16'd3 : 16'(k + 1);
            send(2, 1'b1, 8'd250, 1'b0, 1'b1, 1'b1, sat, "sat_err");
            e++;
            send(2, 1'b1, e, 1'b0, 1'b1, 1'b0, sat, "sat_ok");
            e++;
        end

`ifdef COUNTER_CHECKER_CLR_EN
        send(2, 1'b1, e, 1'b1, 1'b1, 1'b0, 16'd0, "clr_plain");
        e++;
        send(2, 1'b1, 8'd250, 1'b1, 1'b1, 1'b1, 16'd1, "clr_with_err");
        e++;
        send(2, 1'b1, e, 1'b0, 1'b1, 1'b0, 16'd1, "clr_after");
        e++;
`endif

        // async reset mid-run: outputs drop before any further clock edge
        @(negedge clk);
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst.locked0", {15'b0, locked0}, 16'd0);
        check("arst.err0",    err0,             16'd0);
        check("arst.locked1", {15'b0, locked1}, 16'd0);
        check("arst.err1",    err1,             16'd0);
        check("arst.locked2", {15'b0, locked2}, 16'd0);
        check("arst.err2",    {14'b0, err2},    16'd0);
        check("arst.error2",  {15'b0, error2},  16'd0);
        @(negedge clk);
        rst = 1'b0;

        send(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, "post_rst");
        for (int i = 0; i < 6; i++) begin
            send(2, 1'b1, 8'(i + 30), 1'b0, (i >= 4), 1'b0, 16'd0, "post_rst_lock");
        end

        // drain the scoreboard with a bounded wait
        for (int n = 0; n < 10 && sb.size() != 0; n++) begin
            @(negedge clk);
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
